// File: rtl/bound_flasher_ctrlfsm.sv
// Command-side sequencer for the bound flasher lamp bar: walks the output FSM
// through the up/down bound pattern, handles flick kickback and drains after reset.
module bound_flasher_ctrlfsm #(
    parameter logic [4:0] LVL_MAX = 5'd16,
    parameter logic [4:0] LVL_LO  = 5'd5,
    parameter logic [4:0] LVL_HI  = 5'd11,
    parameter logic [4:0] KICK_LO = 5'd6,
    parameter logic [4:0] KICK_HI = 5'd11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flick,
    input  logic [4:0] state,
    output logic       enb,
    output logic       ison,
    output logic       busy,
    output logic [2:0] phase
);

    localparam logic [2:0] P_IDLE  = 3'd0;
    localparam logic [2:0] P_UP_A  = 3'd1;
    localparam logic [2:0] P_DN_A  = 3'd2;
    localparam logic [2:0] P_UP_B  = 3'd3;
    localparam logic [2:0] P_DN_B  = 3'd4;
    localparam logic [2:0] P_UP_C  = 3'd5;
    localparam logic [2:0] P_DN_C  = 3'd6;
    localparam logic [2:0] P_FLUSH = 3'd7;

    logic [2:0] phase_q;
    logic [2:0] phase_d;
    logic       busy_q;
    logic [4:0] target;
    logic       dir_up;
    logic       at_target;
    logic       kick;

    // Per-phase bound and stepping direction; IDLE has neither.
    always_comb begin
        target = 5'd0;
        dir_up = 1'b0;
        case (phase_q)
            P_UP_A:  begin target = LVL_MAX; dir_up = 1'b1; end
            P_DN_A:  begin target = LVL_LO;  dir_up = 1'b0; end
            P_UP_B:  begin target = LVL_HI;  dir_up = 1'b1; end
            P_DN_B:  begin target = 5'd0;    dir_up = 1'b0; end
            P_UP_C:  begin target = LVL_MAX; dir_up = 1'b1; end
            P_DN_C:  begin target = 5'd0;    dir_up = 1'b0; end
            P_FLUSH: begin target = 5'd0;    dir_up = 1'b0; end
            default: begin target = 5'd0;    dir_up = 1'b0; end
        endcase
    end

    assign at_target = (state == target);
    assign kick = flick && ((phase_q == P_UP_B) || (phase_q == P_UP_C)) &&
                  ((state == KICK_LO) || (state == KICK_HI));

    // busy tracks the registered phase, so it is loaded from the next phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= P_FLUSH;
            busy_q  <= 1'b1;
        end else begin
            phase_q <= phase_d;
            busy_q  <= (phase_d != P_IDLE);
        end
    end

    // Kickback outranks target arrival, which outranks the IDLE start request.
    always_comb begin
        phase_d = phase_q;
        if (kick && (phase_q == P_UP_B)) begin
            phase_d = P_DN_A;
        end else if (kick && (phase_q == P_UP_C)) begin
            phase_d = P_DN_B;
        end else if ((phase_q != P_IDLE) && at_target) begin
            case (phase_q)
                P_UP_A:  phase_d = P_DN_A;
                P_DN_A:  phase_d = P_UP_B;
                P_UP_B:  phase_d = P_DN_B;
                P_DN_B:  phase_d = P_UP_C;
                P_UP_C:  phase_d = P_DN_C;
                P_DN_C:  phase_d = P_IDLE;
                P_FLUSH: phase_d = P_IDLE;
                default: phase_d = P_IDLE;
            endcase
        end else if ((phase_q == P_IDLE) && flick && (state == 5'd0)) begin
            phase_d = P_UP_A;
        end
    end

    always_comb begin
        enb  = 1'b0;
        ison = 1'b0;
        if (phase_q != P_IDLE) begin
            enb  = !at_target && !kick;
            ison = dir_up;
        end
    end

    assign phase = phase_q;
    assign busy  = busy_q;

endmodule
